// File: rtl/uart_msg_seq_if.sv
// Bus bundle for uart_msg_seq: message table, run control, status and UART line.
// With UART_MSG_SEQ_STATS_EN defined the bundle also carries the msgs_sent/chars_sent counters.
interface uart_msg_seq_if #(
  parameter int unsigned NUM_MSGS    = 4,
  parameter int unsigned STR_MAX_LEN = 32,
  parameter int unsigned GAP_WIDTH   = 24
);
  localparam int unsigned MSG_WIDTH = 8 * STR_MAX_LEN;
  localparam int unsigned NUM_W     = $clog2(NUM_MSGS + 1);
  localparam int unsigned IDX_W     = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;

  logic [NUM_MSGS*MSG_WIDTH-1:0] msgs;
  logic [NUM_W-1:0]              num_msgs;
  logic                          loop_en;
  logic [GAP_WIDTH-1:0]          gap_cycles;
  logic                          start;
  logic                          stop;
  logic                          busy;
  logic                          done;
  logic [IDX_W-1:0]              msg_idx;
  logic                          utx_pin;
`ifdef UART_MSG_SEQ_STATS_EN
  logic [31:0]                   msgs_sent;
  logic [31:0]                   chars_sent;
`endif

  modport master (
    output msgs, num_msgs, loop_en, gap_cycles, start, stop,
`ifdef UART_MSG_SEQ_STATS_EN
    input  msgs_sent, chars_sent,
`endif
    input  busy, done, msg_idx, utx_pin
  );

  modport slave (
    input  msgs, num_msgs, loop_en, gap_cycles, start, stop,
`ifdef UART_MSG_SEQ_STATS_EN
    output msgs_sent, chars_sent,
`endif
    output busy, done, msg_idx, utx_pin
  );
endinterface

// File: rtl/uart_msg_seq.sv
// uart_msg_seq: sends up to NUM_MSGS strings in order over an 8N1 UART line,
// with a programmable idle gap between messages and optional looping.
// String encoding: first character in the most significant byte of the slot,
// terminated by a NUL byte or by the end of the slot.
// Optional statistics counters are enabled by defining UART_MSG_SEQ_STATS_EN.
module uart_msg_seq #(
  parameter int unsigned CLOCK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned NUM_MSGS    = 4,
  parameter int unsigned STR_MAX_LEN = 32,
  parameter int unsigned GAP_WIDTH   = 24
) (
  input  logic          clk,
  input  logic          rst,
  uart_msg_seq_if.slave bus
);
  localparam int unsigned MSG_WIDTH    = 8 * STR_MAX_LEN;
  localparam int unsigned NUM_W        = $clog2(NUM_MSGS + 1);
  localparam int unsigned IDX_W        = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam int unsigned CNT_W        = $clog2(STR_MAX_LEN + 1);
  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_W-1:0]     num_q, num_d;
  logic                 loop_q, loop_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 s_valid_c;
  logic                 send_end_c;

  // string iterator state
  logic                 it_active_q;
  logic [MSG_WIDTH-1:0] str_q;
  logic [CNT_W-1:0]     cnt_q;

  // uart transmitter state
  logic                 utx_busy_q;
  logic                 pin_q;
  logic [8:0]           frame_q;
  logic [3:0]           bit_cnt_q;
  logic [BAUD_W-1:0]    baud_q;

  logic [NUM_W-1:0]     num_clamped_c;
  logic                 last_slot_c;
  logic [IDX_W-1:0]     next_idx_c;
  logic                 stop_seen_c;
  logic                 s_ready_c;
  logic [7:0]           chr_byte_c;
  logic                 chr_valid_c;
  logic                 utx_en_c;
  logic                 drained_c;
  logic [31:0]          slot_base_c;
  logic [MSG_WIDTH-1:0] slot_c;

  assign num_clamped_c = (bus.num_msgs > NUM_W'(NUM_MSGS)) ? NUM_W'(NUM_MSGS) : bus.num_msgs;
  assign last_slot_c   = (NUM_W'(idx_q) == (num_q - NUM_W'(1)));
  assign next_idx_c    = last_slot_c ? '0 : (idx_q + IDX_W'(1));
  assign stop_seen_c   = stop_pend_q | bus.stop;
  assign slot_base_c   = 32'(idx_q) * MSG_WIDTH;
  assign slot_c        = bus.msgs[slot_base_c +: MSG_WIDTH];
  assign s_ready_c     = !it_active_q;
  assign chr_byte_c    = str_q[MSG_WIDTH-1 -: 8];
  assign chr_valid_c   = it_active_q && (chr_byte_c != 8'h00) && (cnt_q != CNT_W'(STR_MAX_LEN));
  assign utx_en_c      = chr_valid_c && !utx_busy_q;
  assign drained_c     = !chr_valid_c && s_ready_c && !utx_busy_q;

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      num_q       <= '0;
      loop_q      <= 1'b0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      loop_q      <= loop_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Sequencer next-state: load slot, wait for line to drain, gap, advance
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    loop_d      = loop_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    stop_pend_d = stop_pend_q;
    s_valid_c   = 1'b0;
    send_end_c  = 1'b0;
    if (state_q != S_IDLE && bus.stop) stop_pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (num_clamped_c != '0) begin
            num_d       = num_clamped_c;
            loop_d      = bus.loop_en;
            gap_d       = bus.gap_cycles;
            stop_pend_d = 1'b0;
            idx_d       = '0;
            state_d     = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        s_valid_c = 1'b1;
        if (s_ready_c) state_d = S_SEND;
      end
      S_SEND: begin
        if (drained_c) begin
          send_end_c = 1'b1;
          if (stop_seen_c || (last_slot_c && !loop_q)) begin
            state_d = S_DONE;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (stop_seen_c) begin
          state_d = S_DONE;
        end else if (gap_cnt_q == '0) begin
          idx_d   = next_idx_c;
          state_d = S_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_SEND) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // String iterator: walks the loaded slot one byte per accepted character
  always_ff @(posedge clk) begin
    if (rst) begin
      it_active_q <= 1'b0;
      str_q       <= '0;
      cnt_q       <= '0;
    end else if (s_valid_c && s_ready_c) begin
      it_active_q <= 1'b1;
      str_q       <= slot_c;
      cnt_q       <= '0;
    end else if (utx_en_c) begin
      str_q <= str_q << 8;
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (it_active_q && !chr_valid_c) begin
      it_active_q <= 1'b0;
    end
  end

  // UART transmitter: 8N1, LSB first; reset forces the line high at once
  always_ff @(posedge clk) begin
    if (rst) begin
      utx_busy_q <= 1'b0;
      pin_q      <= 1'b1;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      baud_q     <= '0;
    end else if (!utx_busy_q) begin
      if (utx_en_c) begin
        frame_q    <= {1'b1, chr_byte_c};
        pin_q      <= 1'b0;
        utx_busy_q <= 1'b1;
        bit_cnt_q  <= '0;
        baud_q     <= '0;
      end
    end else if (baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
      baud_q <= '0;
      if (bit_cnt_q == 4'd9) begin
        utx_busy_q <= 1'b0;
      end else begin
        pin_q     <= frame_q[0];
        frame_q   <= frame_q >> 1;
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end
    end else begin
      baud_q <= baud_q + BAUD_W'(1);
    end
  end

`ifdef UART_MSG_SEQ_STATS_EN
  logic [31:0] msgs_sent_q;
  logic [31:0] chars_sent_q;

  // Free-running message and character counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      msgs_sent_q  <= '0;
      chars_sent_q <= '0;
    end else begin
      if (send_end_c) msgs_sent_q <= msgs_sent_q + 32'd1;
      if (utx_en_c)   chars_sent_q <= chars_sent_q + 32'd1;
    end
  end

  assign bus.msgs_sent  = msgs_sent_q;
  assign bus.chars_sent = chars_sent_q;
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.msg_idx = idx_q;
  assign bus.utx_pin = pin_q;
endmodule

// File: tb/tb_uart_msg_seq.sv
// Testbench for uart_msg_seq: decodes the UART line and checks each received
// byte against a queue of expected bytes filled when a run is started.
module tb_uart_msg_seq;
  localparam int unsigned NM  = 4;
  localparam int unsigned SML = 4;
  localparam int unsigned MW  = 8 * SML;
  localparam int unsigned GW  = 24;
  localparam int          BIT_CLKS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_msg_seq_if #(.NUM_MSGS(NM), .STR_MAX_LEN(SML), .GAP_WIDTH(GW)) bus ();

  uart_msg_seq #(
    .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
    .NUM_MSGS(NM), .STR_MAX_LEN(SML), .GAP_WIDTH(GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int rx_t[$];
  int idx_seen[$];
  bit idx_rec = 0;

  int  cyc = 0;
  int  done_cnt = 0;
  bit  busy_seen = 0;
  bit  pin_low_seen = 0;
  bit  rx_active = 0;
  int  rx_cnt = 0;
  int  rx_total = 0;
  logic [7:0] rx_shift = 8'h00;
  logic prev_pin = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input string s);
    logic [MW-1:0] v = '0;
    for (int i = 0; i < s.len() && i < SML; i++) v[MW-1-8*i -: 8] = s[i];
    return v;
  endfunction

  task automatic set_slots(input string s0, input string s1, input string s2, input string s3);
    bus.msgs = {mk(s3), mk(s2), mk(s1), mk(s0)};
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int k = 0;
    while (done_cnt == 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
  endtask

  // Line decoder, status monitor and scoreboard comparison
  always @(negedge clk) begin
    cyc++;
    if (bus.done) done_cnt++;
    if (bus.busy) busy_seen = 1;
    if (!bus.utx_pin) pin_low_seen = 1;
    if (idx_rec && bus.busy && (idx_seen.size() == 0 || idx_seen[$] != int'(bus.msg_idx)))
      idx_seen.push_back(int'(bus.msg_idx));
    if (rst) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (prev_pin && !bus.utx_pin) begin
        rx_active = 1;
        rx_cnt = 0;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 15 && rx_cnt <= 85 && ((rx_cnt - 15) % BIT_CLKS) == 0)
        rx_shift = {bus.utx_pin, rx_shift[7:1]};
      if (rx_cnt == 95) begin
        rx_active = 0;
        rx_total++;
        chk("rx_stop_bit", 32'(bus.utx_pin), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte %0h expected none", rx_shift);
        end else begin
          chk("rx_byte", 32'(rx_shift), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_pin = bus.utx_pin;
  end

  // Run "AB","C" once without looping and check order, gap, latency and status
  task automatic run_abc(input string name);
    int lat;
    int gap;
    set_slots("AB", "C", "", "");
    bus.num_msgs = 3'd2;
    bus.loop_en = 1'b0;
    bus.gap_cycles = 24'd50;
    done_cnt = 0;
    rx_t.delete();
    push_str("ABC");
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    lat = 1;
    while (bus.utx_pin && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency_le4"}, 32'(lat <= 4), 32'd1);
    wait_done(name, 1500);
    tick(5);
    chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({name, "_all_rx"}, 32'(exp_q.size()), 32'd0);
    if (rx_t.size() >= 3) gap = rx_t[2] - rx_t[1] - 10 * BIT_CLKS;
    else gap = -1;
    chk({name, "_gap_ge50"}, 32'(gap >= 50), 32'd1);
  endtask

  initial begin
    int k;
    bus.msgs = '0;
    bus.num_msgs = '0;
    bus.loop_en = 1'b0;
    bus.gap_cycles = '0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_idx", 32'(bus.msg_idx), 32'd0);
    chk("reset_pin", 32'(bus.utx_pin), 32'd1);
    @(negedge clk) rst = 1'b0;
    tick(2);

    run_abc("t1");
`ifdef UART_MSG_SEQ_STATS_EN
    chk("stats1_msgs", bus.msgs_sent, 32'd2);
    chk("stats1_chars", bus.chars_sent, 32'd3);
`endif
    run_abc("t1b");
`ifdef UART_MSG_SEQ_STATS_EN
    chk("stats2_msgs", bus.msgs_sent, 32'd4);
    chk("stats2_chars", bus.chars_sent, 32'd6);
`endif

    // looping run with stop during the second 'A'
    bus.loop_en = 1'b1;
    bus.gap_cycles = 24'd10;
    done_cnt = 0;
    rx_total = 0;
    push_str("ABCAB");
    pulse_start();
    k = 0;
    while (!(rx_active && rx_total == 3) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("loop_reached_2nd_A", 32'(rx_active && rx_total == 3), 32'd1);
    @(negedge clk) bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
    wait_done("loop", 1500);
    tick(150);
    chk("loop_done_once", 32'(done_cnt), 32'd1);
    chk("loop_rx_total", 32'(rx_total), 32'd5);
    chk("loop_all_rx", 32'(exp_q.size()), 32'd0);
    chk("loop_busy_after", 32'(bus.busy), 32'd0);

    // empty run
    bus.loop_en = 1'b0;
    bus.num_msgs = 3'd0;
    done_cnt = 0;
    busy_seen = 0;
    pin_low_seen = 0;
    pulse_start();
    chk("zero_done_next", 32'(bus.done), 32'd1);
    tick(20);
    chk("zero_done_once", 32'(done_cnt), 32'd1);
    chk("zero_busy_never", 32'(busy_seen), 32'd0);
    chk("zero_pin_high", 32'(pin_low_seen), 32'd0);

    // empty slot in the middle
    set_slots("X", "", "Y", "");
    bus.num_msgs = 3'd3;
    bus.gap_cycles = 24'd5;
    done_cnt = 0;
    idx_seen.delete();
    idx_rec = 1;
    push_str("XY");
    pulse_start();
    wait_done("empty", 1500);
    idx_rec = 0;
    tick(5);
    chk("empty_all_rx", 32'(exp_q.size()), 32'd0);
    chk("empty_idx_count", 32'(idx_seen.size()), 32'd3);
    for (int i = 0; i < idx_seen.size() && i < 3; i++)
      chk("empty_idx_seq", 32'(idx_seen[i]), 32'(i));

    // reset in the middle of a frame
    set_slots("AB", "C", "", "");
    bus.num_msgs = 3'd2;
    bus.gap_cycles = 24'd5;
    pulse_start();
    k = 0;
    while (!rx_active && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_frame_started", 32'(rx_active), 32'd1);
    tick(30);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pin", 32'(bus.utx_pin), 32'd1);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_idx", 32'(bus.msg_idx), 32'd0);
    rst = 1'b0;
    tick(2);
    bus.num_msgs = 3'd1;
    done_cnt = 0;
    push_str("AB");
    pulse_start();
    wait_done("after_rst", 1500);
    tick(5);
    chk("after_rst_all_rx", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_msg_seq.md
Name: uart_msg_seq

Overview:
- Parametrised UART message sequencer. Successor to the fixed two-string demo.
- Transmits up to NUM_MSGS caller-supplied strings in order over a UART TX pin, with a programmable inter-message gap and optional looping.
- Built on svc_str_iter (string to chars) and svc_uart_tx (chars to pin).
- Sits at board top level for status and banner output.

Parameters:
- CLOCK_FREQ, 100_000_000, clk frequency in Hz; passed to svc_uart_tx.
- BAUD_RATE, 115_200, UART baud; passed to svc_uart_tx.
- NUM_MSGS, 4, number of message slots (>=1).
- STR_MAX_LEN, 32, max bytes per message; MSG_WIDTH = 8*STR_MAX_LEN.
- GAP_WIDTH, 24, width of the gap_cycles counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- msgs  input  NUM_MSGS*MSG_WIDTH  message table; slot i = msgs[i*MSG_WIDTH +: MSG_WIDTH], SVC_STR encoding
- num_msgs  input  $clog2(NUM_MSGS+1)  active slot count; sampled on start
- loop_en  input  1  1 = restart at slot 0 after last slot; sampled on start
- gap_cycles  input  GAP_WIDTH  idle clk cycles between messages; sampled on start
- start  input  1  single-cycle request to begin a run
- stop  input  1  abort request: stop after the current message completes
- busy  output  1  high from accepted start until return to IDLE
- done  output  1  one-cycle pulse when a run ends (normally or by stop)
- msg_idx  output  $clog2(NUM_MSGS)  slot currently being sent
- utx_pin  output  1  UART TX line, idle high

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; busy=0; done=0; msg_idx=0; utx_pin=1.
  - Submodule rst_n is driven as !rst.
  - Reset mid-character aborts the frame immediately; the line returns high next cycle.
- States:
  - IDLE: start=1 with num_msgs!=0 → latch num_msgs, loop_en, gap_cycles; clear stop_pend; idx=0; go LOAD; busy=1 next cycle.
  - IDLE: start=1 with num_msgs=0 → done pulses 1 cycle; busy stays 0.
  - LOAD: present s_valid=1 with slot idx to svc_str_iter; hold until s_ready; go SEND.
  - SEND: wait for drain (str_iter m_valid=0, s_ready=1, utx_busy=0), then:
    - stop_pend set, or (last slot and !loop_en) → DONE.
    - Otherwise → GAP with gap counter = gap_cycles.
  - GAP: decrement each cycle; at 0 → advance idx, go LOAD.
    - Advance is idx+1, or 0 when idx = num_msgs-1 (wrap).
    - gap_cycles=0 → GAP lasts exactly 1 cycle.
    - stop_pend seen in GAP → DONE immediately.
  - DONE: done=1 for one cycle; busy=0; → IDLE.
- stop is latched into stop_pend in any non-IDLE state. It never truncates a message mid-string.
- start while busy is ignored.
- start and stop together in IDLE: start wins, stop ignored.
- num_msgs > NUM_MSGS is clamped to NUM_MSGS.
- Char path: chr_ready = !utx_busy; utx_en = chr_valid && !utx_busy. No chars are dropped or duplicated.
- Empty string slot (first byte NUL) completes with zero chars; sequencing proceeds normally.
- msg_idx updates on entry to LOAD and is stable through SEND/GAP.
- Latency: start to first start-bit falling edge ≤ 4 cycles.

Optional Feature:
- Macro: UART_MSG_SEQ_STATS_EN.
- Defined: adds outputs msgs_sent [31:0] and chars_sent [31:0].
  - Both are free-running counters, cleared by rst only, not by start.
  - msgs_sent increments on each SEND→(GAP|DONE) transition.
  - chars_sent increments on each utx_en.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; remaining behaviour is identical.

Test Plan:
- Common setup: CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clk/bit, 100 clk/char). Bench decodes utx_pin.
- Slots "AB","C", num_msgs=2, loop_en=0, gap_cycles=50, start → bytes 0x41,0x42,0x43 in order; done pulses once; gap between 'B' stop bit and 'C' start bit ≥50 cycles; busy=0 after.
- Same table, loop_en=1, stop asserted during 2nd 'A' → stream "ABCAB", stop after message completes; done once; no partial frame.
- num_msgs=0, start → done pulse next cycle, busy never 1, utx_pin constant 1.
- Slot1 empty string, slots "X","","Y", num_msgs=3 → "XY" on line; msg_idx visits 0,1,2.
- rst asserted mid-'A' frame → utx_pin=1 next cycle, busy=0, msg_idx=0. New start then sends cleanly from slot 0.
- STATS_EN: after the first test, msgs_sent=2 and chars_sent=3. Second identical run → 4 and 6.
